// File: rtl/adder8_rr_sched.sv
// Round-robin scheduler sharing one external 8-bit adder among NREQ requesters,
// chaining carry across multi-beat bursts and returning registered, id-tagged results.
module adder8_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    output logic              add_cin,
    input  logic [7:0]        add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                   state, state_d;
    logic [IDW-1:0]           ptr, owner, sel, cand;
    logic                     carry_q;
    logic                     have_sel, sel_valid, sel_last;
    logic                     can_accept, accept;
    logic                     rsp_valid_q;
    logic [NREQ-1:0][7:0]     a_v, b_v;

    assign a_v        = req_a;
    assign b_v        = req_b;
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = sel_valid && can_accept && !rst;
    assign rsp_valid  = rsp_valid_q && !rst;

    // In LOCKED the owner holds the grant even while its valid is low.
    always_comb begin
        sel      = owner;
        have_sel = 1'b0;
        cand     = '0;
        if (state == LOCKED) begin
            have_sel = 1'b1;
        end else begin
            sel = '0;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IDW'((32'(ptr) + k) % NREQ);
                if (!have_sel && req_valid[cand]) begin
                    have_sel = 1'b1;
                    sel      = cand;
                end
            end
        end
    end

    always_comb begin
        sel_valid = have_sel && req_valid[sel];
        sel_last  = req_last[sel];
        req_ready = '0;
        if (have_sel && !rst) req_ready[sel] = can_accept;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (sel_valid) begin
            add_a   = a_v[sel];
            add_b   = b_v[sel];
            add_cin = (state == LOCKED) ? carry_q : req_cin[sel];
        end
    end

    always_comb begin
        state_d = state;
        if (accept) state_d = sel_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IDW'(NREQ - 1);
            owner       <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id      <= '0;
            rsp_sum     <= '0;
            rsp_cout    <= 1'b0;
            rsp_last    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_id      <= sel;
                rsp_sum     <= add_sum;
                rsp_cout    <= add_cout;
                rsp_last    <= sel_last;
                if (sel_last) begin
                    ptr <= sel;
                end else begin
                    carry_q <= add_cout;
                    owner   <= sel;
                end
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder8_rr_sched.sv
// Bench for adder8_rr_sched: models the shared adder, scoreboards responses,
// and checks grants, burst chaining, back-pressure and reset behaviour.
module tb_adder8_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_cin, req_last, req_ready;
    logic [7:0]        add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic              rsp_valid, rsp_ready, rsp_cout, rsp_last;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_sum;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    adder8_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_last(req_last), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     sum;
        logic           cout;
        logic           last;
    } rsp_t;

    typedef struct {
        int         id;
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    rsp_t q[$];
    vec_t tbl[5];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input int id, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic last);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        mk = '{id: IDW'(id), sum: s[7:0], cout: s[8], last: last};
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic last);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_cin[i]      = cin;
        req_last[i]     = last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Responses are popped on the falling edge preceding the handshake edge.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%0h, required no response", rsp_id, rsp_sum);
            end else begin
                e = q.pop_front();
                check("rsp_id",   32'(rsp_id),   32'(e.id));
                check("rsp_sum",  32'(rsp_sum),  32'(e.sum));
                check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                check("rsp_last", 32'(rsp_last), 32'(e.last));
            end
        end
    end

    initial begin
        tbl[0] = '{id: 0, a: 8'h3C, b: 8'h0F, cin: 1'b1, sum: 8'h4C, cout: 1'b0};
        tbl[1] = '{id: 2, a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        tbl[2] = '{id: 1, a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        tbl[3] = '{id: 3, a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        tbl[4] = '{id: 0, a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0};

        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 4'b1111; req_a = '0; req_b = '0; req_cin = '0; req_last = '1;
        #1;
        check("reset_req_ready_comb", 32'(req_ready), 32'h0);
        step();
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_id",    32'(rsp_id),    0);
        check("reset_rsp_sum",   32'(rsp_sum),   0);
        check("reset_rsp_cout",  32'(rsp_cout),  0);
        check("reset_rsp_last",  32'(rsp_last),  0);

        // single adds from the table
        for (int v = 0; v < 5; v++) begin
            set_req(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].cin, 1'b1);
            req_valid = 4'(1 << tbl[v].id);
            #1;
            check("single_grant", 32'(req_ready), 32'(1 << tbl[v].id));
            q.push_back('{id: IDW'(tbl[v].id), sum: tbl[v].sum, cout: tbl[v].cout, last: 1'b1});
            step();
        end
        req_valid = '0;
        step(); step();

        // round-robin fairness
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h11 * i + 1), 8'(8'h20 + i), i[0], 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % NREQ;
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << g));
            q.push_back(mk(g, 8'(8'h11 * g + 1), 8'(8'h20 + g), g[0], 1'b1));
            step();
        end
        req_valid = '0;
        step(); step();

        // chained burst from req1 with req2 contending
        do_reset();
        set_req(1, 8'hFF, 8'h01, 1'b0, 1'b0);
        set_req(2, 8'h05, 8'h06, 1'b0, 1'b1);
        req_valid = 4'b0110;
        #1;
        check("burst_beat1_grant", 32'(req_ready), 32'b0010);
        q.push_back('{id: 2'd1, sum: 8'h00, cout: 1'b1, last: 1'b0});
        step();
        set_req(1, 8'h01, 8'h00, 1'b1, 1'b1);
        #1;
        check("burst_beat2_grant", 32'(req_ready), 32'b0010);
        check("burst_beat2_cin",   32'(add_cin),   32'(1));
        q.push_back('{id: 2'd1, sum: 8'h02, cout: 1'b0, last: 1'b1});
        step();
        req_valid = 4'b0100;
        #1;
        check("burst_req2_grant", 32'(req_ready), 32'b0100);
        q.push_back('{id: 2'd2, sum: 8'h0B, cout: 1'b0, last: 1'b1});
        step();
        req_valid = '0;
        step(); step();

        // owner drops valid mid-burst; others stay locked out, carry kept
        do_reset();
        set_req(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        set_req(1, 8'h03, 8'h04, 1'b0, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("gap_beat1_grant", 32'(req_ready), 32'b0001);
        q.push_back('{id: 2'd0, sum: 8'hFF, cout: 1'b1, last: 1'b0});
        step();
        req_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("gap_locked_ready", 32'(req_ready), 32'b0001);
            step();
        end
        set_req(0, 8'h00, 8'h00, 1'b0, 1'b1);
        req_valid = 4'b0011;
        #1;
        check("gap_beat2_grant", 32'(req_ready), 32'b0001);
        q.push_back('{id: 2'd0, sum: 8'h01, cout: 1'b0, last: 1'b1});
        step();
        req_valid = 4'b0010;
        #1;
        check("gap_after_grant", 32'(req_ready), 32'b0010);
        q.push_back(mk(1, 8'h03, 8'h04, 1'b0, 1'b1));
        step();
        req_valid = '0;
        step(); step();

        // back-pressure: hold a response for 3 cycles, then drain+accept together
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h11, 8'h22, 1'b0, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("bp_first_grant", 32'(req_ready), 32'b0001);
        q.push_back('{id: 2'd0, sum: 8'h33, cout: 1'b0, last: 1'b1});
        step();
        set_req(0, 8'h40, 8'h02, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready_low",  32'(req_ready), 0);
            check("bp_rsp_valid",  32'(rsp_valid), 1);
            check("bp_rsp_sum",    32'(rsp_sum),   32'h33);
            check("bp_rsp_id",     32'(rsp_id),    0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_drain_accept", 32'(req_ready), 32'b0001);
        q.push_back('{id: 2'd0, sum: 8'h42, cout: 1'b0, last: 1'b1});
        step();
        req_valid = '0;
        #1;
        check("bp_no_bubble", 32'(rsp_sum), 32'h42);
        step(); step();

        // reset in the middle of a burst that left carry set
        set_req(3, 8'h80, 8'h80, 1'b0, 1'b0);
        req_valid = 4'b1000;
        #1;
        check("rst_burst_grant", 32'(req_ready), 32'b1000);
        q.push_back('{id: 2'd3, sum: 8'h00, cout: 1'b1, last: 1'b0});
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        set_req(3, 8'h10, 8'h20, 1'b0, 1'b1);
        req_valid = 4'b1000;
        #1;
        check("rst_ready_comb", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum",   32'(rsp_sum),   0);
        check("rst_rsp_cout",  32'(rsp_cout),  0);
        check("rst_new_grant", 32'(req_ready), 32'b1000);
        check("rst_new_cin",   32'(add_cin),   0);
        q.push_back('{id: 2'd3, sum: 8'h30, cout: 1'b0, last: 1'b1});
        step();
        req_valid = '0;
        step(); step();

        check("scoreboard_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
